// File: rtl/rename_reg_file_pkg.sv
// Shared definitions for the rename register file.
// Holds the bus widths that supply the block's default parameters
// (data bus width, ROB id width) and the read-port source selector.
package rename_reg_file_pkg;

   localparam int DATA_BUS       = 32;
   localparam int ROB_ADDR_WIDTH = 4;
   localparam int ROB_BUS        = ROB_ADDR_WIDTH;

   // Where a read port takes its result from, highest priority first.
   typedef enum logic [2:0] {
      SRC_OFF,
      SRC_FLUSH,
      SRC_RENAME,
      SRC_COMMIT,
      SRC_STORED
   } read_src_e;

endpackage

// File: rtl/rename_reg_read_port.sv
// One read port of the rename register file: combinational forwarding mux
// that merges the stored entry with this cycle's rename/commit/flush.
// Ports:
//   rst                      active-low reset, forces the outputs to zero
//   read_en, read_addr       port enable and register address
//   stored_is_ref/value/tag  stored state of the addressed entry
//   flush, rename_*, commit_* same-cycle write-side activity
//   read_is_ref, read_data   port result (value, or tag zero-extended)
module rename_reg_read_port
   import rename_reg_file_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_BUS,
   parameter int TAG_WIDTH  = ROB_BUS,
   parameter int ADDR_W     = 5
) (
   input  logic                  rst,
   input  logic                  read_en,
   input  logic [ADDR_W-1:0]     read_addr,
   input  logic                  stored_is_ref,
   input  logic [DATA_WIDTH-1:0] stored_value,
   input  logic [TAG_WIDTH-1:0]  stored_tag,
   input  logic                  flush,
   input  logic                  rename_en,
   input  logic [ADDR_W-1:0]     rename_addr,
   input  logic [TAG_WIDTH-1:0]  rename_tag,
   input  logic                  commit_en,
   input  logic [ADDR_W-1:0]     commit_addr,
   input  logic [TAG_WIDTH-1:0]  commit_tag,
   input  logic [DATA_WIDTH-1:0] commit_data,
   output logic                  read_is_ref,
   output logic [DATA_WIDTH-1:0] read_data
);

   read_src_e src;
   logic      commit_hit;

   assign commit_hit = commit_en && (commit_addr == read_addr);

   always_comb begin
      src = SRC_STORED;
      if (!rst || !read_en || (read_addr == '0))
         src = SRC_OFF;
      else if (flush)
         src = SRC_FLUSH;
      else if (rename_en && (rename_addr == read_addr))
         src = SRC_RENAME;
      // a commit only forwards when it retires the producer currently named
      else if (commit_hit && stored_is_ref && (stored_tag == commit_tag))
         src = SRC_COMMIT;
   end

   always_comb begin
      read_is_ref = 1'b0;
      read_data   = '0;
      case (src)
         SRC_OFF: begin
            read_is_ref = 1'b0;
            read_data   = '0;
         end
         SRC_FLUSH: begin
            read_is_ref = 1'b0;
            read_data   = commit_hit ? commit_data : stored_value;
         end
         SRC_RENAME: begin
            read_is_ref = 1'b1;
            read_data   = DATA_WIDTH'(rename_tag);
         end
         SRC_COMMIT: begin
            read_is_ref = 1'b0;
            read_data   = commit_data;
         end
         default: begin
            read_is_ref = stored_is_ref;
            read_data   = stored_is_ref ? DATA_WIDTH'(stored_tag) : stored_value;
         end
      endcase
   end

endmodule

// File: rtl/rename_reg_file.sv
// Architectural register file with rename tags. Each entry holds either a
// committed value or the ROB id of its in-flight producer.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   rename_en/addr/tag       dispatch marks a register as renamed
//   commit_en/addr/tag/data  ROB retires a result
//   flush                    clears every rename tag (mispredict recovery)
//   read_en, read_addr       NUM_READ flattened read ports
//   read_is_ref, read_data   per-port result (value, or tag zero-extended)
//   pending_count            number of registers currently renamed
module rename_reg_file
   import rename_reg_file_pkg::*;
#(
   parameter int  DATA_WIDTH = DATA_BUS,
   parameter int  TAG_WIDTH  = ROB_BUS,
   parameter int  REG_COUNT  = 32,
   parameter int  NUM_READ   = 2,
   localparam int ADDR_W     = $clog2(REG_COUNT)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           rename_en,
   input  logic [ADDR_W-1:0]              rename_addr,
   input  logic [TAG_WIDTH-1:0]           rename_tag,
   input  logic                           commit_en,
   input  logic [ADDR_W-1:0]              commit_addr,
   input  logic [TAG_WIDTH-1:0]           commit_tag,
   input  logic [DATA_WIDTH-1:0]          commit_data,
   input  logic                           flush,
   input  logic [NUM_READ-1:0]            read_en,
   input  logic [NUM_READ*ADDR_W-1:0]     read_addr,
   output logic [NUM_READ-1:0]            read_is_ref,
   output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
   output logic [ADDR_W:0]                pending_count
);

   localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

   logic [REG_COUNT-1:0]  is_ref_q;
   logic [DATA_WIDTH-1:0] value_q [REG_COUNT];
   logic [TAG_WIDTH-1:0]  tag_q   [REG_COUNT];

   logic rename_live;
   logic commit_live;
   logic commit_match;
   logic cnt_inc;
   logic cnt_dec;

   // Register 0 is hardwired: writes to it are simply never qualified.
   assign rename_live  = rename_en && !flush && (rename_addr != '0);
   assign commit_live  = commit_en && (commit_addr != '0);
   assign commit_match = commit_live && is_ref_q[commit_addr]
                         && (tag_q[commit_addr] == commit_tag);

   // A same-register rename re-marks the entry, so its commit frees nothing.
   assign cnt_inc = rename_live && !is_ref_q[rename_addr];
   assign cnt_dec = commit_match && !(rename_live && (rename_addr == commit_addr));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         is_ref_q      <= '0;
         pending_count <= '0;
         for (int i = 0; i < REG_COUNT; i++) begin
            value_q[i] <= '0;
            tag_q[i]   <= '0;
         end
      end else begin
         if (commit_live)
            value_q[commit_addr] <= commit_data;

         if (flush) begin
            is_ref_q <= '0;
         end else begin
            if (commit_match)
               is_ref_q[commit_addr] <= 1'b0;
            // rename is last so it wins over a same-register commit
            if (rename_live) begin
               is_ref_q[rename_addr] <= 1'b1;
               tag_q[rename_addr]    <= rename_tag;
            end
         end

         if (flush)
            pending_count <= '0;
         else if (cnt_inc && !cnt_dec)
            pending_count <= pending_count + CNT_ONE;
         else if (cnt_dec && !cnt_inc)
            pending_count <= pending_count - CNT_ONE;
      end
   end

   for (genvar i = 0; i < NUM_READ; i++) begin : g_read
      logic [ADDR_W-1:0] addr_i;
      assign addr_i = read_addr[i*ADDR_W +: ADDR_W];

      rename_reg_read_port #(
         .DATA_WIDTH (DATA_WIDTH),
         .TAG_WIDTH  (TAG_WIDTH),
         .ADDR_W     (ADDR_W)
      ) u_port (
         .rst           (rst),
         .read_en       (read_en[i]),
         .read_addr     (addr_i),
         .stored_is_ref (is_ref_q[addr_i]),
         .stored_value  (value_q[addr_i]),
         .stored_tag    (tag_q[addr_i]),
         .flush         (flush),
         .rename_en     (rename_en),
         .rename_addr   (rename_addr),
         .rename_tag    (rename_tag),
         .commit_en     (commit_en),
         .commit_addr   (commit_addr),
         .commit_tag    (commit_tag),
         .commit_data   (commit_data),
         .read_is_ref   (read_is_ref[i]),
         .read_data     (read_data[i*DATA_WIDTH +: DATA_WIDTH])
      );
   end

endmodule

// File: tb/tb_rename_reg_file.sv
// Directed bench for rename_reg_file: default instance (32 regs, 2 ports)
// plus a 64-register, 4-port instance for the wide forwarding case.
module tb_rename_reg_file;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   // default instance
   logic        rename_en, commit_en, flush;
   logic [4:0]  rename_addr, commit_addr;
   logic [3:0]  rename_tag, commit_tag;
   logic [31:0] commit_data;
   logic [1:0]  read_en;
   logic [9:0]  read_addr;
   logic [1:0]  read_is_ref;
   logic [63:0] read_data;
   logic [5:0]  pending_count;

   // wide instance
   logic         b_rename_en, b_commit_en, b_flush;
   logic [5:0]   b_rename_addr, b_commit_addr;
   logic [3:0]   b_rename_tag, b_commit_tag;
   logic [31:0]  b_commit_data;
   logic [3:0]   b_read_en;
   logic [23:0]  b_read_addr;
   logic [3:0]   b_read_is_ref;
   logic [127:0] b_read_data;
   logic [6:0]   b_pending_count;

   rename_reg_file u_dut (
      .clk           (clk),
      .rst           (rst),
      .rename_en     (rename_en),
      .rename_addr   (rename_addr),
      .rename_tag    (rename_tag),
      .commit_en     (commit_en),
      .commit_addr   (commit_addr),
      .commit_tag    (commit_tag),
      .commit_data   (commit_data),
      .flush         (flush),
      .read_en       (read_en),
      .read_addr     (read_addr),
      .read_is_ref   (read_is_ref),
      .read_data     (read_data),
      .pending_count (pending_count)
   );

   rename_reg_file #(.REG_COUNT(64), .NUM_READ(4)) u_dut_wide (
      .clk           (clk),
      .rst           (rst),
      .rename_en     (b_rename_en),
      .rename_addr   (b_rename_addr),
      .rename_tag    (b_rename_tag),
      .commit_en     (b_commit_en),
      .commit_addr   (b_commit_addr),
      .commit_tag    (b_commit_tag),
      .commit_data   (b_commit_data),
      .flush         (b_flush),
      .read_en       (b_read_en),
      .read_addr     (b_read_addr),
      .read_is_ref   (b_read_is_ref),
      .read_data     (b_read_data),
      .pending_count (b_pending_count)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic idle();
      rename_en = 1'b0; commit_en = 1'b0; flush = 1'b0;
      rename_addr = '0; rename_tag = '0;
      commit_addr = '0; commit_tag = '0; commit_data = '0;
   endtask

   task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
      read_en   = 2'b11;
      read_addr = {a1, a0};
   endtask

   task automatic ren(input logic [4:0] a, input logic [3:0] t);
      rename_en = 1'b1; rename_addr = a; rename_tag = t;
   endtask

   task automatic com(input logic [4:0] a, input logic [3:0] t, input logic [31:0] d);
      commit_en = 1'b1; commit_addr = a; commit_tag = t; commit_data = d;
   endtask

   // drives happen 1 time unit after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      idle();
      rd(5'd5, 5'd5);
      b_rename_en = 1'b0; b_commit_en = 1'b0; b_flush = 1'b0;
      b_rename_addr = '0; b_rename_tag = '0;
      b_commit_addr = '0; b_commit_tag = '0; b_commit_data = '0;
      b_read_en = '0; b_read_addr = '0;

      #2;
      chk("reset_ref",   64'(read_is_ref), 64'd0);
      chk("reset_data",  read_data, 64'd0);
      chk("reset_count", 64'(pending_count), 64'd0);

      #5 rst = 1'b1;
      step();

      // rename r3 with same-cycle read, then commit with same-cycle read
      ren(5'd3, 4'd7); rd(5'd3, 5'd3);
      #1;
      chk("ren_fwd_ref",  64'(read_is_ref), 64'h3);
      chk("ren_fwd_d0",   64'(read_data[31:0]), 64'd7);
      chk("ren_fwd_d1",   64'(read_data[63:32]), 64'd7);
      step(); idle();
      chk("ren_count", 64'(pending_count), 64'd1);
      com(5'd3, 4'd7, 32'hDEADBEEF);
      #1;
      chk("com_fwd_ref", 64'(read_is_ref), 64'h0);
      chk("com_fwd_d0",  64'(read_data[31:0]), 64'hDEADBEEF);
      step(); idle();
      chk("com_count",  64'(pending_count), 64'd0);
      chk("com_stored", 64'(read_data[31:0]), 64'hDEADBEEF);

      // stale commit leaves the newer rename in place
      ren(5'd4, 4'd2); step();
      ren(5'd4, 4'd9); step();
      idle(); com(5'd4, 4'd2, 32'h11); rd(5'd4, 5'd4);
      #1;
      chk("stale_fwd_ref", 64'(read_is_ref), 64'h3);
      chk("stale_fwd_d0",  64'(read_data[31:0]), 64'd9);
      step(); idle();
      chk("stale_count", 64'(pending_count), 64'd1);
      chk("stale_ref",   64'(read_is_ref), 64'h3);
      chk("stale_data",  64'(read_data[31:0]), 64'd9);
      com(5'd4, 4'd9, 32'h22); step(); idle();
      chk("late_count", 64'(pending_count), 64'd0);
      chk("late_ref",   64'(read_is_ref), 64'h0);
      chk("late_data",  64'(read_data[31:0]), 64'h22);

      // same-register rename + matching commit: value written, rename wins
      ren(5'd8, 4'd3); step();
      ren(5'd8, 4'd4); com(5'd8, 4'd3, 32'h77); rd(5'd8, 5'd8);
      #1;
      chk("rc_fwd_ref", 64'(read_is_ref), 64'h3);
      chk("rc_fwd_d0",  64'(read_data[31:0]), 64'd4);
      step(); idle();
      chk("rc_count", 64'(pending_count), 64'd1);
      chk("rc_data",  64'(read_data[31:0]), 64'd4);
      com(5'd8, 4'd4, 32'h88); step(); idle();
      chk("rc2_count", 64'(pending_count), 64'd0);
      chk("rc2_data",  64'(read_data[31:0]), 64'h88);

      // flush with same-cycle commit and dropped rename
      ren(5'd1, 4'd1); step();
      ren(5'd2, 4'd2); step();
      ren(5'd6, 4'd6); step(); idle();
      chk("pre_flush_count", 64'(pending_count), 64'd3);
      flush = 1'b1; com(5'd2, 4'd0, 32'h55); ren(5'd7, 4'd5); rd(5'd2, 5'd6);
      #1;
      chk("flush_fwd_ref", 64'(read_is_ref), 64'h0);
      chk("flush_fwd_d0",  64'(read_data[31:0]), 64'h55);
      chk("flush_fwd_d1",  64'(read_data[63:32]), 64'h0);
      step(); idle(); rd(5'd2, 5'd7);
      chk("flush_count", 64'(pending_count), 64'd0);
      chk("flush_ref",   64'(read_is_ref), 64'h0);
      chk("flush_r2",    64'(read_data[31:0]), 64'h55);
      rd(5'd1, 5'd6);
      #1;
      chk("flush_r1r6_ref", 64'(read_is_ref), 64'h0);

      // register 0 ignores writes
      ren(5'd0, 4'd5); com(5'd0, 4'd0, 32'h1); rd(5'd0, 5'd0);
      #1;
      chk("r0_fwd_ref", 64'(read_is_ref), 64'h0);
      chk("r0_fwd_data", read_data, 64'h0);
      step(); idle();
      chk("r0_count", 64'(pending_count), 64'd0);
      chk("r0_data",  read_data, 64'h0);

      // per-port enable
      read_en = 2'b01; read_addr = {5'd4, 5'd4};
      #1;
      chk("en_data", read_data, {32'h0, 32'h22});

      // asynchronous reset mid-burst
      rd(5'd9, 5'd10);
      ren(5'd9, 4'd1); step();
      ren(5'd10, 4'd2); step();
      ren(5'd11, 4'd3);
      #1;
      chk("burst_count", 64'(pending_count), 64'd2);
      chk("burst_ref",   64'(read_is_ref), 64'h3);
      #2 rst = 1'b0;
      #1;
      chk("async_ref",   64'(read_is_ref), 64'h0);
      chk("async_data",  read_data, 64'h0);
      chk("async_count", 64'(pending_count), 64'd0);
      step();
      chk("held_count", 64'(pending_count), 64'd0);
      idle();
      #2 rst = 1'b1;
      step();
      rd(5'd3, 5'd9);
      #1;
      chk("post_rst_ref",  64'(read_is_ref), 64'h0);
      chk("post_rst_data", read_data, 64'h0);

      // wide instance: 4 ports, r63 renamed in the same cycle
      b_commit_en = 1'b1; b_commit_addr = 6'd1; b_commit_data = 32'h1234;
      step();
      b_commit_en = 1'b0;
      b_rename_en = 1'b1; b_rename_addr = 6'd63; b_rename_tag = 4'hA;
      b_read_en = 4'hF; b_read_addr = {6'd0, 6'd63, 6'd1, 6'd63};
      #1;
      chk("wide_ref", 64'(b_read_is_ref), 64'h5);
      chk("wide_d0",  64'(b_read_data[31:0]),   64'hA);
      chk("wide_d1",  64'(b_read_data[63:32]),  64'h1234);
      chk("wide_d2",  64'(b_read_data[95:64]),  64'hA);
      chk("wide_d3",  64'(b_read_data[127:96]), 64'h0);
      step();
      b_rename_en = 1'b0;
      chk("wide_count", 64'(b_pending_count), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
